// File: rtl/alu_mul_seq.sv
// Iterative radix-2 shift-and-add multiplier for MUL/MULH/MULHSU/MULHU.
// Define MUL_EARLY_EXIT_EN to finish CALC early once the remaining multiplier bits are zero.
module alu_mul_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic            i_flush,
    input  logic [1:0]      i_op,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CALC  = 2'd1;
    localparam logic [1:0] S_FINAL = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [1:0] OP_MUL  = 2'b00;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   mcand_q, mcand_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [1:0]        op_q, op_d;
    logic              neg_q, neg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              rs1_neg, rs2_neg;
    logic [XLEN-1:0]   mag1, mag2;
    logic [XLEN:0]     sum;
    logic [2*XLEN:0]   step_w;
    logic [2*XLEN-1:0] prod_step, prod_fix;

    // Upper half accumulates; lower half starts as the multiplier and is consumed from bit 0.
    assign rs1_neg   = (i_op == 2'b01 || i_op == 2'b10) && i_rs1[XLEN-1];
    assign rs2_neg   = (i_op == 2'b01) && i_rs2[XLEN-1];
    assign mag1      = rs1_neg ? -i_rs1 : i_rs1;
    assign mag2      = rs2_neg ? -i_rs2 : i_rs2;
    assign sum       = {1'b0, prod_q[2*XLEN-1:XLEN]} + {1'b0, mcand_q};
    assign step_w    = {prod_q[0] ? sum : {1'b0, prod_q[2*XLEN-1:XLEN]}, prod_q[XLEN-1:0]};
    assign prod_step = step_w[2*XLEN:1];
    assign prod_fix  = neg_q ? -prod_q : prod_q;

`ifdef MUL_EARLY_EXIT_EN
    logic [XLEN-1:0]  rem_mask;
    logic [CNT_W-1:0] shamt;
    logic             rem_zero;
    assign rem_mask = {XLEN{1'b1}} >> cnt_q;
    assign rem_zero = (prod_q[XLEN-1:0] & rem_mask) == '0;
    assign shamt    = CNT_W'(XLEN) - cnt_q;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        prod_d   = prod_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    mcand_d = mag1;
                    prod_d  = {{XLEN{1'b0}}, mag2};
                    op_d    = i_op;
                    neg_d   = rs1_neg ^ rs2_neg;
                    cnt_d   = '0;
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN-1)) state_d = S_FINAL;
`ifdef MUL_EARLY_EXIT_EN
                // Nothing left to add: align the partial product and finish now.
                if (rem_zero) begin
                    prod_d  = prod_q >> shamt;
                    state_d = S_FINAL;
                end
`endif
            end
            S_FINAL: begin
                result_d = (op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
        if (i_flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            prod_q   <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            prod_q   <= prod_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign o_busy   = state_q != S_IDLE;
    assign o_valid  = state_q == S_DONE;
    assign o_result = result_q;
endmodule

// File: tb/tb_alu_mul_seq.sv
// Directed-vector bench for alu_mul_seq: results, latency, and abort/flush/reset control cases.
module tb_alu_mul_seq;
    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] rs1, rs2;
    logic        busy, valid;
    logic [31:0] result;
    int          n_chk = 0;
    int          n_pass = 0;

    alu_mul_seq #(.XLEN(32), .CNT_W(6)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_flush(flush),
        .i_op(op), .i_rs1(rs1), .i_rs2(rs2),
        .o_busy(busy), .o_valid(valid), .o_result(result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accept happens on the edge inside this task; operands are scrambled afterwards.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; rs1 = a; rs2 = b;
        step();
        start = 1'b0; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
    endtask

    task automatic wait_valid(output int edges);
        edges = 0;
        while (!valid && edges < 100) begin
            step();
            edges++;
        end
    endtask

    task automatic count_valid(input int cycles, output int nv);
        nv = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (valid) nv++;
        end
    endtask

    task automatic run(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp);
        int e;
        issue(o, a, b);
        wait_valid(e);
`ifndef MUL_EARLY_EXIT_EN
        chk({tag, "_lat"}, 64'(e), 64'd33);
`endif
        chk(tag, 64'(result), 64'(exp));
        step();
        chk({tag, "_end"}, 64'({busy, valid}), 64'd0);
    endtask

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] a64, b64, p;
        a64 = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'd0, a};
        b64 = (o == 2'b01) ? {{32{b[31]}}, b} : {32'd0, b};
        p   = a64 * b64;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    initial begin
        int e, nv;
        logic [31:0] a, b;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
        repeat (3) step();
        rst = 1'b0;
        chk("rst_state", 64'({busy, valid, result}), 64'd0);

        run("mul_7x6",       2'b00, 32'd7,        32'd6,        32'h0000002A);
        run("mulh_m1m1",     2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run("mul_m1m1",      2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run("mulhu_m1m1",    2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run("mulhsu_m1x2",   2'b10, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
        run("mulhu_m1x2",    2'b11, 32'hFFFFFFFF, 32'h00000002, 32'h00000001);
        run("mulh_minmin",   2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
        run("mulh_minx1",    2'b01, 32'h80000000, 32'h00000001, 32'hFFFFFFFF);
        run("mul_minmin",    2'b00, 32'h80000000, 32'h80000000, 32'h00000000);
        run("mulhsu_minxm1", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run("mulhu_x10",     2'b11, 32'h12345678, 32'h00000010, 32'h00000001);
        run("mul_x10",       2'b00, 32'h12345678, 32'h00000010, 32'h23456780);
        run("mul_zero",      2'b01, 32'hDEADBEEF, 32'h00000000, 32'h00000000);

        // Second start mid-CALC must not disturb the running op.
        issue(2'b00, 32'd7, 32'd6);
        repeat (5) step();
        start = 1'b1; op = 2'b11; rs1 = 32'hFFFFFFFF; rs2 = 32'hFFFFFFFF;
        step();
        start = 1'b0;
        wait_valid(e);
`ifndef MUL_EARLY_EXIT_EN
        chk("restart_lat", 64'(e), 64'd27);
`endif
        chk("restart_res", 64'(result), 64'h2A);
        // Start during DONE is dropped.
        start = 1'b1; op = 2'b11; rs1 = 32'd3; rs2 = 32'd3;
        step();
        start = 1'b0;
        chk("done_start_busy", 64'(busy), 64'd0);
        step();
        chk("done_start_busy2", 64'(busy), 64'd0);

        // Flush mid-CALC.
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_busy", 64'(busy), 64'd0);
        count_valid(40, nv);
        chk("flush_novalid", 64'(nv), 64'd0);
        chk("flush_hold", 64'(result), 64'h2A);

        // Flush while in FINAL must not update the result.
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (32) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_final", 64'({busy, valid, result}), 64'h2A);

        // Flush beats start in IDLE.
        start = 1'b1; flush = 1'b1; op = 2'b00; rs1 = 32'd5; rs2 = 32'd5;
        step();
        start = 1'b0; flush = 1'b0;
        chk("flush_start_idle", 64'(busy), 64'd0);
        run("post_flush", 2'b00, 32'd9, 32'd9, 32'd81);

        // Reset mid-CALC.
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid", 64'({busy, valid, result}), 64'd0);
        count_valid(40, nv);
        chk("rst_novalid", 64'(nv), 64'd0);

        // Reset beats start.
        rst = 1'b1; start = 1'b1; op = 2'b00; rs1 = 32'd2; rs2 = 32'd2;
        step();
        rst = 1'b0; start = 1'b0;
        chk("rst_start", 64'(busy), 64'd0);

        for (int k = 0; k < 120; k++) begin
            a = ($urandom_range(0, 3) == 0) ? 32'h80000000 : $urandom;
            b = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
            run("rand", 2'(k % 4), a, b, ref_mul(2'(k % 4), a, b));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
